// File: rtl/imm_ext_pipe.sv
// Immediate / load-data extension unit (SEXT, ZEXT, LUI, LB/LBU, LH/LHU, LW) for the MIPS datapath.
// Latency: STAGES cycles; extension is combinational into stage 0, then STAGES-1 plain register stages.
// Backpressure: elastic valid/ready pipe; ready ripples back combinationally, full throughput, no bubbles.
module imm_ext_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int STAGES    = 2,
    localparam int OFF_W    = $clog2(OUT_WIDTH / 8)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [2:0]           Mode,
    input  logic [OUT_WIDTH-1:0] Data_IN,
    input  logic [OFF_W-1:0]     Byte_Off,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [OUT_WIDTH-1:0] Ext_OUT,
    output logic                 Misalign,
    output logic [7:0]           Misalign_Cnt
);

    localparam int FILL_W = OUT_WIDTH - IN_WIDTH;

    logic [IN_WIDTH-1:0]  imm;
    logic [OFF_W+2:0]     byte_idx;
    logic [OFF_W+2:0]     half_idx;
    logic [7:0]           byte_lane;
    logic [15:0]          half_lane;
    logic [OUT_WIDTH-1:0] ext_res;
    logic                 ext_mis;

    // Per-stage state: valid, data, misalign flag; index STAGES-1 is the output stage.
    logic [STAGES-1:0]    v;
    logic [STAGES-1:0]    ms;
    logic [OUT_WIDTH-1:0] dq [STAGES];
    logic [STAGES-1:0]    load;

    assign imm      = Data_IN[IN_WIDTH-1:0];
    // Little-endian lane select; the half lane drops the low offset bit (floor lane).
    assign byte_idx = {Byte_Off, 3'b000};
    assign half_idx = {Byte_Off[OFF_W-1:1], 4'b0000};
    assign byte_lane = Data_IN[byte_idx +: 8];
    assign half_lane = Data_IN[half_idx +: 16];

    // Mode decode: extended value and misalignment flag for the incoming transfer.
    always_comb begin
        ext_res = '0;
        ext_mis = 1'b0;
        case (Mode)
            3'd0: ext_res = {{FILL_W{imm[IN_WIDTH-1]}}, imm};
            3'd1: ext_res = {{FILL_W{1'b0}}, imm};
            3'd2: ext_res = {imm, {FILL_W{1'b0}}};
            3'd3: ext_res = {{(OUT_WIDTH-8){byte_lane[7]}}, byte_lane};
            3'd4: ext_res = {{(OUT_WIDTH-8){1'b0}}, byte_lane};
            3'd5: begin
                ext_res = {{(OUT_WIDTH-16){half_lane[15]}}, half_lane};
                ext_mis = Byte_Off[0];
            end
            3'd6: begin
                ext_res = {{(OUT_WIDTH-16){1'b0}}, half_lane};
                ext_mis = Byte_Off[0];
            end
            default: begin
                ext_res = Data_IN;
                ext_mis = |Byte_Off;
            end
        endcase
    end

    // Stage k may load when any stage from k to the output has a hole, or the head leaves.
    always_comb begin
        load = '0;
        for (int k = 0; k < STAGES; k++) begin
            load[k] = Out_Ready;
            for (int j = 0; j < STAGES; j++) begin
                if (j >= k && !v[j]) begin
                    load[k] = 1'b1;
                end
            end
        end
    end

    assign In_Ready  = load[0];
    assign Out_Valid = v[STAGES-1];
    assign Ext_OUT   = dq[STAGES-1];
    assign Misalign  = ms[STAGES-1];

    // Pipe advance; payload only moves with a valid token so an empty output keeps its last value.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            v            <= '0;
            ms           <= '0;
            Misalign_Cnt <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dq[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                v[0] <= In_Valid;
                if (In_Valid) begin
                    dq[0] <= ext_res;
                    ms[0] <= ext_mis;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        dq[k] <= dq[k-1];
                        ms[k] <= ms[k-1];
                    end
                end
            end
            if (v[STAGES-1] && Out_Ready && ms[STAGES-1] && (Misalign_Cnt != 8'hFF)) begin
                Misalign_Cnt <= Misalign_Cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: three instances (S=2 16->32, S=1 16->32, S=4 12->64) share one stimulus.
// Each instance has its own queue-based reference; directed literals pin the S=2 instance.
// Backpressure, saturation, mid-stream reset and random valid/ready traffic are exercised.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  mode = '0;
    logic [63:0] data_in = '0;
    logic [2:0]  byte_off = '0;

    logic [63:0] ext_o [3];
    logic        ir [3];
    logic        ov [3];
    logic        mis [3];
    logic [7:0]  mcnt [3];
    int          pend [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Reference extension written from the mode definitions: {misalign, value}.
    function automatic logic [64:0] ref_ext(input logic [2:0] md, input logic [63:0] d,
                                            input int off, input int iw, input int ow);
        logic [63:0] om, im, r, lane;
        logic        m;
        om = (ow == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ow) - 64'd1);
        im = (64'd1 << iw) - 64'd1;
        r = '0;
        m = 1'b0;
        case (md)
            3'd0: begin
                r = d & im;
                if (d[iw-1]) r = r | (om & ~im);
            end
            3'd1: r = d & im;
            3'd2: r = ((d & im) << (ow - iw)) & om;
            3'd3, 3'd4: begin
                lane = (d >> (8 * off)) & 64'hFF;
                r = lane;
                if (md == 3'd3 && lane[7]) r = (om & ~64'hFF) | lane;
            end
            3'd5, 3'd6: begin
                lane = (d >> (16 * (off / 2))) & 64'hFFFF;
                r = lane;
                if (md == 3'd5 && lane[15]) r = (om & ~64'hFFFF) | lane;
                m = (off % 2) == 1;
            end
            default: begin
                r = d & om;
                m = off != 0;
            end
        endcase
        return {m, r};
    endfunction

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : gen
            localparam int IW  = (g == 2) ? 12 : 16;
            localparam int OW  = (g == 2) ? 64 : 32;
            localparam int ST  = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
            localparam int OFW = $clog2(OW / 8);

            logic [OW-1:0] e;
            logic          ir_l, ov_l, mis_l;
            logic [7:0]    mc_l;
            logic [64:0]   q [$];
            int            cnt = 0;

            imm_ext_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .STAGES(ST)) dut (
                .CLK(clk), .RST(rst), .In_Valid(in_valid), .In_Ready(ir_l),
                .Mode(mode), .Data_IN(data_in[OW-1:0]), .Byte_Off(byte_off[OFW-1:0]),
                .Out_Valid(ov_l), .Out_Ready(out_ready), .Ext_OUT(e),
                .Misalign(mis_l), .Misalign_Cnt(mc_l)
            );

            assign ext_o[g] = 64'(e);
            assign ir[g]    = ir_l;
            assign ov[g]    = ov_l;
            assign mis[g]   = mis_l;
            assign mcnt[g]  = mc_l;

            // Compare on the falling edge: outputs and handshakes are settled for the coming edge.
            always @(negedge clk) begin
                if (!rst) begin
                    q.delete();
                    cnt = 0;
                end else begin
                    tests++;
                    if (mc_l !== 8'(cnt)) begin
                        fails++;
                        $display("FAIL sb%0d_cnt: got %0d want %0d", g, mc_l, cnt);
                    end
                    if (ov_l === 1'b1) begin
                        tests++;
                        if (q.size() == 0) begin
                            fails++;
                            $display("FAIL sb%0d_spurious: Out_Valid=1 ext=%h with nothing pending", g, e);
                        end else begin
                            if ({mis_l, 64'(e)} !== q[0]) begin
                                fails++;
                                $display("FAIL sb%0d_out: got mis=%0b ext=%h want mis=%0b ext=%h",
                                         g, mis_l, e, q[0][64], q[0][63:0]);
                            end
                            if (out_ready) begin
                                if (q[0][64] && cnt < 255) cnt++;
                                void'(q.pop_front());
                            end
                        end
                    end
                    if (in_valid && ir_l) begin
                        q.push_back(ref_ext(mode, data_in & ((OW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF),
                                            int'(byte_off) % (OW / 8), IW, OW));
                    end
                end
                pend[g] = q.size();
            end
        end
    endgenerate

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  md;
        logic [31:0] d;
        logic [2:0]  off;
        logic [31:0] x;
        logic        xm;
        logic [7:0]  xc;
    } vec_t;

    vec_t vt [14];

    // One isolated transfer through the S=2 instance, checked against literals.
    task automatic run_vec(input int i);
        mode     = vt[i].md;
        data_in  = {32'h0, vt[i].d};
        byte_off = vt[i].off;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk($sformatf("vec%0d_lat_early", i), 64'(ov[0]), 64'd0);
        @(posedge clk); #1;
        chk($sformatf("vec%0d_valid", i), 64'(ov[0]), 64'd1);
        chk($sformatf("vec%0d_ext", i), ext_o[0], {32'h0, vt[i].x});
        chk($sformatf("vec%0d_mis", i), 64'(mis[0]), 64'(vt[i].xm));
        chk($sformatf("vec%0d_cnt", i), 64'(mcnt[0]), 64'(vt[i].xc));
    endtask

    localparam int STG [3] = '{2, 1, 4};

    initial begin
        int idx;
        int bound;

        vt[0]  = '{3'd0, 32'h0000_8001, 3'd0, 32'hFFFF_8001, 1'b0, 8'd0};
        vt[1]  = '{3'd1, 32'h0000_8001, 3'd0, 32'h0000_8001, 1'b0, 8'd0};
        vt[2]  = '{3'd2, 32'h0000_1234, 3'd0, 32'h1234_0000, 1'b0, 8'd0};
        vt[3]  = '{3'd0, 32'hDEAD_7FFF, 3'd3, 32'h0000_7FFF, 1'b0, 8'd0};
        vt[4]  = '{3'd1, 32'hFFFF_0005, 3'd1, 32'h0000_0005, 1'b0, 8'd0};
        vt[5]  = '{3'd3, 32'h80FF_7F01, 3'd0, 32'h0000_0001, 1'b0, 8'd0};
        vt[6]  = '{3'd3, 32'h80FF_7F01, 3'd1, 32'h0000_007F, 1'b0, 8'd0};
        vt[7]  = '{3'd3, 32'h80FF_7F01, 3'd2, 32'hFFFF_FFFF, 1'b0, 8'd0};
        vt[8]  = '{3'd3, 32'h80FF_7F01, 3'd3, 32'hFFFF_FF80, 1'b0, 8'd0};
        vt[9]  = '{3'd4, 32'h80FF_7F01, 3'd3, 32'h0000_0080, 1'b0, 8'd0};
        vt[10] = '{3'd5, 32'h80FF_7F01, 3'd2, 32'hFFFF_80FF, 1'b0, 8'd0};
        vt[11] = '{3'd6, 32'h80FF_7F01, 3'd0, 32'h0000_7F01, 1'b0, 8'd0};
        vt[12] = '{3'd5, 32'h80FF_7F01, 3'd1, 32'h0000_7F01, 1'b1, 8'd0};
        vt[13] = '{3'd7, 32'h80FF_7F01, 3'd2, 32'h80FF_7F01, 1'b1, 8'd1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ov[0]), 64'd0);
        chk("rst_ext", ext_o[0], 64'd0);
        chk("rst_mis", 64'(mis[0]), 64'd0);
        chk("rst_cnt", 64'(mcnt[0]), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed modes and misalignment
        for (int i = 0; i < 14; i++) run_vec(i);
        @(posedge clk); #1;
        chk("mis_cnt_after_two", 64'(mcnt[0]), 64'd2);

        // Saturation: 300 back-to-back misaligned words
        mode = 3'd7; data_in = 64'h1122_3344_5566_7788; byte_off = 3'd2; in_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mis_cnt_sat", 64'(mcnt[0]), 64'd255);
        chk("mis_cnt_sat_s4", 64'(mcnt[2]), 64'd255);

        // Backpressure: 6 tagged immediates, output stalled for 5 cycles
        out_ready = 1'b0; mode = 3'd1; byte_off = 3'd0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            data_in  = 64'(16'h0A00 + idx);
            @(negedge clk);
            if (ir[0]) idx++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", 64'(idx), 64'd2);
        chk("bp_in_ready", 64'(ir[0]), 64'd0);
        chk("bp_out_valid", 64'(ov[0]), 64'd1);
        chk("bp_out_hold", ext_o[0], 64'h0A00);
        out_ready = 1'b1;
        bound = 0;
        while (idx < 6 && bound < 50) begin
            data_in = 64'(16'h0A00 + idx);
            @(negedge clk);
            if (ir[0]) idx++;
            @(posedge clk); #1;
            bound++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 64'(idx), 64'd6);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_drained", 64'(pend[0]), 64'd0);
        chk("bp_empty", 64'(ov[0]), 64'd0);

        // Reset with two results in flight
        out_ready = 1'b0; mode = 3'd7; byte_off = 3'd1; data_in = 64'hCAFE_F00D; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_mid_valid%0d", i), 64'(ov[i]), 64'd0);
            chk($sformatf("rst_mid_cnt%0d", i), 64'(mcnt[i]), 64'd0);
        end
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;

        // First post-reset transfer emerges after exactly STAGES edges
        mode = 3'd0; data_in = 64'h0042; byte_off = 3'd0; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int i = 0; i < 3; i++)
                chk($sformatf("lat_e%0d_i%0d", k, i), 64'(ov[i]), 64'(k == STG[i]));
        end
        chk("lat_val_s4", ext_o[2], 64'h42);

        // Random valid/ready traffic, all instances against their reference queues
        for (int c = 0; c < 1500; c++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            mode      = 3'($urandom_range(0, 7));
            byte_off  = 3'($urandom_range(0, 7));
            data_in   = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("rand_drained%0d", i), 64'(pend[i]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate/load-data extension unit for the MIPS datapath. Generalises the 16→32 sign extender into eight modes: sign/zero immediate extension, LUI placement, and byte/halfword load extraction with sign or zero fill. The unit is an elastic pipeline of configurable depth with a valid/ready handshake on both sides. It sits between decode/memory-read and the execute/writeback operand muxes.

## Interface
- IN_WIDTH, 16, immediate field width; must satisfy 1 ≤ IN_WIDTH < OUT_WIDTH.
- OUT_WIDTH, 32, datapath width; a multiple of 16 and ≥ 32.
- STAGES, 2, pipeline depth (1..4); equals the latency in cycles.
- OFF_W, derived = $clog2(OUT_WIDTH/8), byte-offset width (not user-set).
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset.
- In_Valid  in  1  upstream has a transfer.
- In_Ready  out  1  unit accepts a transfer this cycle.
- Mode  in  3  operation select.
- Data_IN  in  OUT_WIDTH  immediate in bits [IN_WIDTH-1:0] (modes 0–2) or the loaded word (modes 3–7).
- Byte_Off  in  OFF_W  little-endian byte address offset.
- Out_Valid  out  1  Ext_OUT holds a result.
- Out_Ready  in  1  downstream accepts.
- Ext_OUT  out  OUT_WIDTH  extended result.
- Misalign  out  1  the result at the output came from a misaligned half/word access.
- Misalign_Cnt  out  8  saturating count of misaligned results delivered.

## Operation
- Mode 0 SEXT: the top bit of the immediate is replicated into bits [OUT_WIDTH-1:IN_WIDTH].
- Mode 1 ZEXT: the immediate is zero-filled.
- Mode 2 LUI: immediate << (OUT_WIDTH-IN_WIDTH); the low bits are zero.
- Mode 3 LB / mode 4 LBU: byte lane Data_IN[8*Byte_Off +: 8], sign-filled or zero-filled.
- Mode 5 LH / mode 6 LHU: half lane Data_IN[16*(Byte_Off>>1) +: 16], sign-filled or zero-filled.
- Mode 7 LW: Data_IN passes through unchanged.
- Misalign = 1 for modes 5/6 when Byte_Off[0]=1, and for mode 7 when Byte_Off≠0. The data is still produced as defined above: half uses the floor lane; word ignores the offset.
- Byte_Off is ignored in modes 0–3/4 for the misalignment check. Modes 0–2 ignore Data_IN[OUT_WIDTH-1:IN_WIDTH].
- Extension is combinational into stage 0. Stages 1..STAGES-1 are pure registers, each holding {valid, data, misalign}.
- Stage k loads when it is empty or when its contents leave in the same cycle: load_k = !v_k | (next stage loads, or Out_Ready for the last stage).
- In_Ready = load_0. Ready propagates combinationally back through the stages, giving full throughput with no bubbles.
- An upstream transfer occurs on In_Valid & In_Ready. A downstream transfer occurs on Out_Valid & Out_Ready.
- Out_Valid = v_last. Ext_OUT and Misalign come from the last stage.
- Misalign_Cnt increments on each downstream transfer with Misalign=1 and saturates at 255.

## Timing
- Reset (RST=0 at an edge): all valid bits = 0, all data = 0, Misalign = 0, Misalign_Cnt = 0. Out_Valid = 0 on the next cycle.
- In_Ready is combinational; it may be 1 during reset while the pipe is empty, but no transfer is captured while RST=0.
- Latency: a transfer accepted at edge n appears at Out_Valid after edge n+STAGES-1. Stage 0 registers at edge n, so STAGES=1 gives Out_Valid in the cycle following acceptance.
- Throughput: one result per cycle while Out_Ready=1.
- Stall: while Out_Valid & !Out_Ready, Ext_OUT, Misalign and Out_Valid hold stable. The pipe fills; In_Ready falls once all stages are valid.
- Full pipe with Out_Ready=1: the input is accepted in the same cycle the head leaves (simultaneous in/out). Occupancy is unchanged.
- Empty pipe: Out_Valid=0. Ext_OUT holds its last value and must be ignored.
- Reset mid-stream: in-flight results are discarded. No partial output or count update occurs on the reset edge.
- Misalign_Cnt at 255: further misaligned deliveries leave it at 255.

## Test plan
- Reset, then with STAGES=2, Out_Ready=1, send Mode0 imm 0x8001 → Ext_OUT=0xFFFF8001 two edges later; Mode1 0x8001 → 0x00008001; Mode2 0x1234 → 0x12340000.
- Data_IN=0x80FF7F01: LB off 0..3 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; LBU off 3 → 0x00000080; LH off 2 → 0xFFFF80FF; LHU off 0 → 0x00007F01.
- Misalignment: LH off 1 → Ext_OUT=sign-extended half lane 0, Misalign=1. LW off 2 → Data_IN unchanged, Misalign=1, Misalign_Cnt increments once per delivery. Drive 300 misaligned deliveries → Misalign_Cnt=255.
- Backpressure: stream 6 tagged immediates, hold Out_Ready=0 for 5 cycles → In_Ready=0 after STAGES acceptances and output stable. Release → all 6 delivered in order, no loss or duplication.
- Random valid/ready toggling against a scoreboard for STAGES=1 and STAGES=4, and IN_WIDTH=12, OUT_WIDTH=64 → output order and values match the reference model.
- Assert RST=0 with 2 results in flight → Out_Valid=0 and Misalign_Cnt=0 after the edge. First post-reset input emerges after exactly STAGES edges.
